// File: rtl/spi_master_pkg.sv
// Shared types and constants for the single-byte SPI master.
package spi_master_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned NUM_EDGES = 2 * DATA_W;
    // Wide enough to count the SCLK edges plus the closing HOLD tick.
    localparam int unsigned EDGE_W    = $clog2(NUM_EDGES + 2);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StTransfer,
        StHold,
        StDone
    } state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK prescaler and edge counter: emits leading/trailing strobes and the registered SCLK level.
module spi_clk_gen
    import spi_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              cpol_i,
    output logic              lead_o,
    output logic              trail_o,
    output logic              done_o,
    output logic [EDGE_W-1:0] edge_o,
    output logic              sclk_o
);

    localparam int unsigned   DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    logic [DivW-1:0]   div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              sclk_q, sclk_d;
    logic              tick;
    logic              in_burst;

    always_comb begin
        tick     = run_i && (div_q == DivMax);
        in_burst = edge_q < EDGE_W'(NUM_EDGES);
        // edge_q counts completed edges, so an even count means the next one is leading.
        lead_o   = tick && in_burst && !edge_q[0];
        trail_o  = tick && in_burst && edge_q[0];
        done_o   = tick && !in_burst;

        div_d  = div_q;
        edge_d = edge_q;
        sclk_d = sclk_q;
        if (!run_i) begin
            div_d  = '0;
            edge_d = '0;
            sclk_d = cpol_i;
        end else if (tick) begin
            div_d = '0;
            if (in_burst) begin
                edge_d = edge_q + 1'b1;
                sclk_d = ~sclk_q;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            edge_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

    assign edge_o = edge_q;
    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master, all four CPOL/CPHA modes, MSB first, registered outputs.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] datain,
    input  logic              start,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              miso,
    output logic              sclk,
    output logic              ss,
    output logic              mosi,
    output logic              finish,
    output logic [DATA_W-1:0] dataout
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              finish_q, finish_d;

    logic              run;
    logic              cpol_sel;
    logic              lead, trail, done;
    logic [EDGE_W-1:0] edge_cnt;
    logic              last_trail;
    logic              sample;

    assign run        = (state_q == StSetup) || (state_q == StTransfer) || (state_q == StHold);
    // SCLK follows the live CPOL input only while idle.
    assign cpol_sel   = (state_q == StIdle) ? CPOL : cpol_q;
    assign last_trail = trail && (edge_cnt == EDGE_W'(NUM_EDGES - 1));

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .run_i   (run),
        .cpol_i  (cpol_sel),
        .lead_o  (lead),
        .trail_o (trail),
        .done_o  (done),
        .edge_o  (edge_cnt),
        .sclk_o  (sclk)
    );

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        dout_d   = dout_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        ss_d     = ss_q;
        mosi_d   = mosi_q;
        finish_d = 1'b0;

        sample = (lead && !cpha_q) || (trail && cpha_q);
        if (sample) begin
            rx_d = {rx_q[DATA_W-2:0], miso};
        end
        // CPHA=0 already presented the MSB at start, so it shifts on trailing edges except the last.
        if (lead && cpha_q) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
        end else if (trail && !cpha_q && !last_trail) begin
            mosi_d = tx_q[DATA_W-2];
            tx_d   = tx_q << 1;
        end

        unique case (state_q)
            StIdle: begin
                ss_d   = 1'b1;
                mosi_d = 1'b0;
                if (start) begin
                    state_d = StSetup;
                    tx_d    = datain;
                    rx_d    = '0;
                    cpol_d  = CPOL;
                    cpha_d  = CPHA;
                    ss_d    = 1'b0;
                    mosi_d  = CPHA ? 1'b0 : datain[DATA_W-1];
                end
            end
            StSetup: begin
                if (lead) begin
                    state_d = StTransfer;
                end
            end
            StTransfer: begin
                if (last_trail) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (done) begin
                    state_d  = StDone;
                    ss_d     = 1'b1;
                    finish_d = 1'b1;
                    dout_d   = rx_q;
                end
            end
            StDone: begin
                state_d = StIdle;
                mosi_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            tx_q     <= '0;
            rx_q     <= '0;
            dout_q   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            ss_q     <= 1'b1;
            mosi_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            dout_q   <= dout_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            ss_q     <= ss_d;
            mosi_q   <= mosi_d;
            finish_q <= finish_d;
        end
    end

    assign ss      = ss_q;
    assign mosi    = mosi_q;
    assign finish  = finish_q;
    assign dataout = dout_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave and an expected-byte scoreboard.
module tb_spi_master;

    localparam int Div = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       CPOL;
    logic       CPHA;
    logic       miso = 1'b0;
    logic [7:0] datain;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       finish;
    logic [7:0] dataout;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mexp_q[$];

    // Slave model state
    logic       s_pol = 1'b0;
    logic       s_pha = 1'b0;
    logic [7:0] s_bytes[0:7];
    int         s_idx = 0;
    logic [7:0] s_tx;
    logic [7:0] s_rx;
    int         s_bit;
    int         s_edges = 0;
    logic [7:0] s_cap = 8'h00;
    int         s_cap_edges = 0;
    logic       s_prev_ss;
    logic       s_prev_sclk;

    spi_master #(
        .CLK_DIV (Div)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .datain  (datain),
        .start   (start),
        .CPOL    (CPOL),
        .CPHA    (CPHA),
        .miso    (miso),
        .sclk    (sclk),
        .ss      (ss),
        .mosi    (mosi),
        .finish  (finish),
        .dataout (dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: drives miso on its launch edges and shifts in mosi on its capture edges.
    always @(ss or sclk) begin
        if (ss === 1'b0 && s_prev_ss !== 1'b0) begin
            s_tx    = s_bytes[s_idx % 8];
            s_idx   = s_idx + 1;
            s_edges = 0;
            s_rx    = 8'h00;
            s_bit   = 7;
            if (!s_pha) begin
                miso  = s_tx[7];
                s_bit = 6;
            end
        end else if (ss !== 1'b0 && s_prev_ss === 1'b0) begin
            s_cap       = s_rx;
            s_cap_edges = s_edges;
        end else if (ss === 1'b0 && sclk !== s_prev_sclk) begin
            s_edges = s_edges + 1;
            if (sclk !== s_pol) begin
                if (s_pha) begin
                    miso  = s_tx[s_bit];
                    s_bit = s_bit - 1;
                end else begin
                    s_rx = {s_rx[6:0], mosi};
                end
            end else begin
                if (s_pha) begin
                    s_rx = {s_rx[6:0], mosi};
                end else if (s_edges < 16) begin
                    miso  = s_tx[s_bit];
                    s_bit = s_bit - 1;
                end
            end
        end
        s_prev_ss   = ss;
        s_prev_sclk = sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input logic [7:0] tx, input logic [7:0] rx, input logic pol,
                           input logic pha, input string tag);
        int         cnt;
        logic [7:0] e;
        s_pol  = pol;
        s_pha  = pha;
        CPOL   = pol;
        CPHA   = pha;
        datain = tx;
        s_bytes[s_idx % 8] = rx;
        exp_q.push_back(rx);
        mexp_q.push_back(tx);
        repeat (3) @(negedge clk);
        chk({tag, " idle sclk"}, 32'(sclk), 32'(pol));
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        datain = ~tx;
        CPOL   = ~pol;
        CPHA   = ~pha;
        cnt = 0;
        while (ss === 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk({tag, " ss low cycles"}, 32'(cnt), 32'(17 * Div));
        chk({tag, " finish"}, 32'(finish), 32'd1);
        e = exp_q.pop_front();
        chk({tag, " dataout"}, 32'(dataout), 32'(e));
        e = mexp_q.pop_front();
        chk({tag, " mosi byte"}, 32'(s_cap), 32'(e));
        chk({tag, " sclk edges"}, 32'(s_cap_edges), 32'd16);
        chk({tag, " rest sclk"}, 32'(sclk), 32'(pol));
        @(negedge clk);
        chk({tag, " finish width"}, 32'(finish), 32'd0);
        CPOL = pol;
        CPHA = pha;
    endtask

    initial begin
        int nfin;
        int t0;
        int t1;
        int gap;
        int cnt;
        int fin;
        logic [7:0] e;

        rst    = 1'b1;
        start  = 1'b0;
        datain = 8'h00;
        CPOL   = 1'b0;
        CPHA   = 1'b0;
        for (int i = 0; i < 8; i++) s_bytes[i] = 8'h00;
        #3 rst = 1'b0;

        // Reset held while start toggles
        repeat (4) begin
            @(negedge clk);
            start = ~start;
        end
        start = 1'b0;
        @(negedge clk);
        chk("reset ss", 32'(ss), 32'd1);
        chk("reset sclk", 32'(sclk), 32'd0);
        chk("reset mosi", 32'(mosi), 32'd0);
        chk("reset finish", 32'(finish), 32'd0);
        chk("reset dataout", 32'(dataout), 32'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("post-reset ss idle", 32'(ss), 32'd1);
        chk("post-reset no select", 32'(s_idx), 32'd0);

        do_xfer(8'hAA, 8'h5C, 1'b0, 1'b0, "mode0");
        do_xfer(8'h3C, 8'hA5, 1'b1, 1'b1, "mode3");
        do_xfer(8'h81, 8'h7E, 1'b0, 1'b1, "mode1");
        do_xfer(8'h81, 8'h7E, 1'b1, 1'b0, "mode2");

        // Back-to-back with start held high
        s_pol  = 1'b0;
        s_pha  = 1'b0;
        CPOL   = 1'b0;
        CPHA   = 1'b0;
        datain = 8'hAA;
        s_bytes[s_idx % 8]       = 8'hC3;
        s_bytes[(s_idx + 1) % 8] = 8'h3C;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h3C);
        mexp_q.push_back(8'hAA);
        mexp_q.push_back(8'h55);
        repeat (2) @(negedge clk);
        nfin = 0;
        t0   = 0;
        t1   = 0;
        gap  = 0;
        start = 1'b1;
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            if (t == 10) datain = 8'h55;
            if (finish === 1'b1) begin
                if (nfin == 0) t0 = t;
                else t1 = t;
                nfin++;
                e = exp_q.pop_front();
                chk("b2b dataout", 32'(dataout), 32'(e));
                e = mexp_q.pop_front();
                chk("b2b mosi byte", 32'(s_cap), 32'(e));
            end
            if (nfin == 1 && ss === 1'b1) gap++;
            if (nfin == 2) break;
        end
        start = 1'b0;
        exp_q.delete();
        mexp_q.delete();
        chk("b2b finish count", 32'(nfin), 32'd2);
        chk("b2b finish spacing", 32'(t1 - t0), 32'(17 * Div + 2));
        chk("b2b ss gap", 32'(gap), 32'd2);
        repeat (4) @(negedge clk);

        // Abort after five SCLK edges
        datain = 8'hF0;
        s_bytes[s_idx % 8] = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (s_edges < 5 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("abort edges reached", 32'(s_edges), 32'd5);
        #1 rst = 1'b0;
        #1;
        chk("abort ss", 32'(ss), 32'd1);
        chk("abort sclk", 32'(sclk), 32'd0);
        chk("abort mosi", 32'(mosi), 32'd0);
        chk("abort finish", 32'(finish), 32'd0);
        chk("abort dataout", 32'(dataout), 32'd0);
        fin = 0;
        repeat (5) begin
            @(negedge clk);
            if (finish === 1'b1) fin++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (finish === 1'b1) fin++;
        end
        chk("abort no finish", 32'(fin), 32'd0);

        do_xfer(8'hC5, 8'h96, 1'b0, 1'b0, "post-abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
